writeback_bypass_pipe: RTL

// - Producer side of operand forwarding: carries each instruction's destination tag (Rd, RegWrite) and

---
 rtl/writeback_bypass_pipe_pkg.sv | 23 ++
 rtl/writeback_bypass_pipe_if.sv | 42 ++++
 rtl/writeback_bypass_pipe_pipe_tag_reg.sv | 38 +++
 rtl/writeback_bypass_pipe.sv | 83 ++++++++
 4 files changed

// File: rtl/writeback_bypass_pipe_pkg.sv
// Shared definitions for the writeback/bypass producer pipeline: default
// widths, the x0 register tag, forwarding-select encodings and a helper that
// gates register writes aimed at x0.
package writeback_bypass_pipe_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 32;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Forwarding mux select seen by the consumer side of operand forwarding
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    // A register write only counts when it targets something other than x0
    function automatic logic writes_reg(input logic reg_write, input logic [4:0] rd);
        return reg_write && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/writeback_bypass_pipe_if.sv
// Bundle of the EX/ID inputs and MEM/WB outputs of the writeback bypass pipe.
// The master side (the surrounding core) drives stage inputs; the slave side
// (the pipe) returns the forwarding tags, data, hazard flag and counter.
interface writeback_bypass_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) ();

    logic             stall_i;
    logic             flush_i;
    logic [4:0]       EXRd_i;
    logic             EXRegWrite_i;
    logic             EXMemRead_i;
    logic [XLEN-1:0]  EXResult_i;
    logic [XLEN-1:0]  MEMLoadData_i;
    logic [4:0]       IDRs1_i;
    logic [4:0]       IDRs2_i;

    logic [4:0]       MEMRd_o;
    logic             MEMRegWrite_o;
    logic [XLEN-1:0]  MEMResult_o;
    logic [4:0]       WBRd_o;
    logic             WBRegWrite_o;
    logic [XLEN-1:0]  WBData_o;
    logic             LoadUseStall_o;
    logic [CNT_W-1:0] WBCount_o;

    modport master (
        output stall_i, flush_i, EXRd_i, EXRegWrite_i, EXMemRead_i, EXResult_i,
               MEMLoadData_i, IDRs1_i, IDRs2_i,
        input  MEMRd_o, MEMRegWrite_o, MEMResult_o, WBRd_o, WBRegWrite_o,
               WBData_o, LoadUseStall_o, WBCount_o
    );

    modport slave (
        input  stall_i, flush_i, EXRd_i, EXRegWrite_i, EXMemRead_i, EXResult_i,
               MEMLoadData_i, IDRs1_i, IDRs2_i,
        output MEMRd_o, MEMRegWrite_o, MEMResult_o, WBRd_o, WBRegWrite_o,
               WBData_o, LoadUseStall_o, WBCount_o
    );

endinterface

// File: rtl/writeback_bypass_pipe_pipe_tag_reg.sv
// One pipeline register carrying a destination tag, write enable, load flag
// and data word. Holds on stall, turns the instruction into a bubble on
// flush, and never lets a write enable through for x0.
module pipe_tag_reg
    import writeback_bypass_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [4:0]      rd_d,
    input  logic            reg_write_d,
    input  logic            mem_read_d,
    input  logic [XLEN-1:0] data_d,
    output logic [4:0]      rd_q,
    output logic            reg_write_q,
    output logic            mem_read_q,
    output logic [XLEN-1:0] data_q
);

    // Capture the incoming stage unless frozen; flush clears only the control bits
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_q        <= REG_X0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            data_q      <= '0;
        end else if (!stall_i) begin
            rd_q        <= rd_d;
            reg_write_q <= writes_reg(reg_write_d, rd_d) & ~flush_i;
            mem_read_q  <= mem_read_d & ~flush_i;
            data_q      <= data_d;
        end
    end

endmodule

// File: rtl/writeback_bypass_pipe.sv
// Producer side of operand forwarding: moves each instruction's destination
// tag and result through EX/MEM and MEM/WB, selects load data at MEM, flags
// load-use hazards for ID and counts register writes entering MEM/WB.
module writeback_bypass_pipe
    import writeback_bypass_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    writeback_bypass_pipe_if.slave  bus
);

    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic [XLEN-1:0]  mem_result;

    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic [XLEN-1:0]  wb_data;
    logic [CNT_W-1:0] wb_count;

    logic             load_use_hit;

    pipe_tag_reg #(
        .XLEN (XLEN)
    ) u_ex_mem (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .stall_i     (bus.stall_i),
        .flush_i     (bus.flush_i),
        .rd_d        (bus.EXRd_i),
        .reg_write_d (bus.EXRegWrite_i),
        .mem_read_d  (bus.EXMemRead_i),
        .data_d      (bus.EXResult_i),
        .rd_q        (mem_rd),
        .reg_write_q (mem_reg_write),
        .mem_read_q  (mem_mem_read),
        .data_q      (mem_result)
    );

    // MEM/WB register: a load retires the memory read data, anything else its ALU result
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_rd        <= REG_X0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
        end else if (!bus.stall_i) begin
            wb_rd        <= mem_rd;
            wb_reg_write <= mem_reg_write;
            wb_data      <= mem_mem_read ? bus.MEMLoadData_i : mem_result;
        end
    end

    // Count every register write as it enters MEM/WB; wraps freely
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_count <= '0;
        end else if (!bus.stall_i && mem_reg_write) begin
            wb_count <= wb_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // A load in EX whose destination is read by ID cannot be forwarded in time
    always_comb begin
        load_use_hit = 1'b0;
        if (bus.EXMemRead_i && writes_reg(bus.EXRegWrite_i, bus.EXRd_i) && !bus.flush_i) begin
            load_use_hit = (bus.IDRs1_i == bus.EXRd_i) || (bus.IDRs2_i == bus.EXRd_i);
        end
    end

    assign bus.MEMRd_o        = mem_rd;
    assign bus.MEMRegWrite_o  = mem_reg_write;
    assign bus.MEMResult_o    = mem_result;
    assign bus.WBRd_o         = wb_rd;
    assign bus.WBRegWrite_o   = wb_reg_write;
    assign bus.WBData_o       = wb_data;
    assign bus.LoadUseStall_o = load_use_hit;
    assign bus.WBCount_o      = wb_count;

endmodule
